memory_controller: RTL and testbench



---
 rtl/memory_controller.sv | 106 ++++++++++
 tb/tb_memory_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/memory_controller.sv
// Word-addressed RAM behind a request/response handshake: latches one request,
// waits a fixed latency, performs the access and pulses memory_response once.
module memory_controller #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 65536,
  parameter int          LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] locator_bus,
  input  logic [DATA_WIDTH-1:0] write_bus,
  input  logic                  memory_mode,
  input  logic                  memory_request,
  output logic                  memory_response,
  output logic [DATA_WIDTH-1:0] read_bus,
  output logic                  busy,
  output logic                  addr_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK, RELEASE} state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      count;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  write_q;
  logic                  in_range;
  logic                  access;
  logic [IDX_W-1:0]      idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign in_range = (32'(addr_q) < DEPTH);
  assign idx      = addr_q[IDX_W-1:0];
  assign access   = (state == BUSY) && (count == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (memory_request) state_next = BUSY;
      BUSY:    if (count == '0)    state_next = ACK;
      ACK:                         state_next = RELEASE;
      RELEASE: if (!memory_request) state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  always_comb begin
    memory_response = (state == ACK);
    busy            = (state != IDLE);
  end

  // Operands are captured only when a request is accepted; later input
  // changes are ignored until the next IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && memory_request) begin
      addr_q  <= locator_bus;
      data_q  <= write_bus;
      write_q <= memory_mode;
    end
  end

  // NOTE: the RAM array has no reset; contents survive reset, and a reset
  // arriving in BUSY suppresses the pending write.
  always_ff @(posedge clk) begin
    if (!reset && access && write_q && in_range) mem[idx] <= data_q;
  end

  // BUSY spans LATENCY+1 cycles so the access and response land LATENCY+1
  // edges after the request is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      read_bus   <= '0;
      addr_error <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (memory_request) count <= CNT_W'(LATENCY);
        BUSY: begin
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            if (!in_range) addr_error <= 1'b1;
            if (!write_q)  read_bus   <= in_range ? mem[idx] : '0;
          end
        end
        ACK:     addr_error <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: default build, a DEPTH=256 build for
// out-of-range accesses and a LATENCY=1 build for response timing.
module tb_memory_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [3];
  logic [15:0] loc  [3];
  logic [15:0] wr   [3];
  logic [15:0] rd   [3];
  logic        mode [3];
  logic        req  [3];
  logic        resp [3];
  logic        busy [3];
  logic        aerr [3];

  int n_cmp = 0;
  int n_bad = 0;
  int pulses [3] = '{0, 0, 0};

  memory_controller #(.LATENCY(2)) dut0 (
    .clk(clk), .reset(rst[0]), .locator_bus(loc[0]), .write_bus(wr[0]),
    .memory_mode(mode[0]), .memory_request(req[0]), .memory_response(resp[0]),
    .read_bus(rd[0]), .busy(busy[0]), .addr_error(aerr[0]));

  memory_controller #(.DEPTH(256), .LATENCY(2)) dut1 (
    .clk(clk), .reset(rst[1]), .locator_bus(loc[1]), .write_bus(wr[1]),
    .memory_mode(mode[1]), .memory_request(req[1]), .memory_response(resp[1]),
    .read_bus(rd[1]), .busy(busy[1]), .addr_error(aerr[1]));

  memory_controller #(.LATENCY(1)) dut2 (
    .clk(clk), .reset(rst[2]), .locator_bus(loc[2]), .write_bus(wr[2]),
    .memory_mode(mode[2]), .memory_request(req[2]), .memory_response(resp[2]),
    .read_bus(rd[2]), .busy(busy[2]), .addr_error(aerr[2]));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) if (resp[i]) pulses[i]++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete transaction from IDLE; returns read data, error flag and the
  // number of edges from request sampling to response.
  task automatic txn(input int d, input logic m, input logic [15:0] a, input logic [15:0] w,
                     output logic [15:0] r, output logic e, output int lat);
    bit seen = 0;
    r = '0; e = 1'b0; lat = -1;
    @(negedge clk);
    loc[d] = a; wr[d] = w; mode[d] = m; req[d] = 1'b1;
    @(posedge clk);
    #1;
    loc[d] = ~a; wr[d] = ~w; mode[d] = ~m;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp[d]) begin
        seen = 1; lat = k; r = rd[d]; e = aerr[d];
      end
    end
    @(negedge clk);
    check("resp_width", resp[d], 1'b0);
    req[d] = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0] burst [7] = '{16'h2000, 16'h0006, 16'hADD0, 16'h0000, 16'hBBBB, 16'h0002, 16'h0001};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] r;
    logic        e;
    int          lat;
    int          p;

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; loc[i] = '0; wr[i] = '0; mode[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    check("rst_resp", resp[0], 1'b0);
    check("rst_busy", busy[0], 1'b0);
    check("rst_read_bus", rd[0], 16'h0000);
    check("rst_addr_error", aerr[0], 1'b0);

    // Write then read back with latency measurement
    txn(0, 1'b1, 16'h0010, 16'hBEEF, r, e, lat);
    check("wr_latency", lat, 3);
    txn(0, 1'b0, 16'h0010, 16'h0000, r, e, lat);
    check("rd_latency", lat, 3);
    check("rd_data", r, 16'hBEEF);
    check("rd_no_err", e, 1'b0);

    // Loader-style burst
    #1 p = pulses[0];
    for (int i = 0; i < 7; i++) txn(0, 1'b1, 16'(i), burst[i], r, e, lat);
    #1 check("burst_pulses", pulses[0] - p, 7);
    for (int i = 0; i < 7; i++) begin
      txn(0, 1'b0, 16'(i), 16'h0000, r, e, lat);
      check($sformatf("burst_rd%0d", i), r, burst[i]);
    end

    // Request held long after a single read
    #1 p = pulses[0];
    @(negedge clk);
    loc[0] = 16'h0010; mode[0] = 1'b0; req[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("held_busy_early", busy[0], 1'b1);
    repeat (12) @(negedge clk);
    check("held_busy_late", busy[0], 1'b1);
    req[0] = 1'b0;
    @(negedge clk);
    check("held_busy_released", busy[0], 1'b0);
    #1 check("held_pulses", pulses[0] - p, 1);
    check("held_data", rd[0], 16'hBEEF);

    // Reset during BUSY aborts the write
    txn(0, 1'b1, 16'h0005, 16'h0000, r, e, lat);
    @(negedge clk);
    loc[0] = 16'h0005; wr[0] = 16'hAAAA; mode[0] = 1'b1; req[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b1; req[0] = 1'b0;
    #1 p = pulses[0];
    @(negedge clk);
    rst[0] = 1'b0;
    check("abort_busy", busy[0], 1'b0);
    check("abort_read_bus", rd[0], 16'h0000);
    repeat (5) @(negedge clk);
    #1 check("abort_no_pulse", pulses[0] - p, 0);
    txn(0, 1'b0, 16'h0005, 16'h0000, r, e, lat);
    check("abort_mem5", r, 16'h0000);

    // Out-of-range accesses on the DEPTH=256 build
    txn(1, 1'b1, 16'h0000, 16'h5A5A, r, e, lat);
    check("oor_inrange_wr_err", e, 1'b0);
    txn(1, 1'b1, 16'h00FF, 16'h7777, r, e, lat);
    txn(1, 1'b1, 16'h0100, 16'h1234, r, e, lat);
    check("oor_wr_err", e, 1'b1);
    check("oor_err_cleared", aerr[1], 1'b0);
    txn(1, 1'b0, 16'h0000, 16'h0000, r, e, lat);
    check("oor_mem0", r, 16'h5A5A);
    txn(1, 1'b0, 16'h0100, 16'h0000, r, e, lat);
    check("oor_rd_err", e, 1'b1);
    check("oor_rd_zero", r, 16'h0000);
    txn(1, 1'b0, 16'h00FF, 16'h0000, r, e, lat);
    check("oor_top_word", r, 16'h7777);
    check("oor_top_err", e, 1'b0);

    // LATENCY=1 build
    txn(2, 1'b1, 16'h0042, 16'hC0DE, r, e, lat);
    check("l1_wr_latency", lat, 2);
    txn(2, 1'b0, 16'h0042, 16'h0000, r, e, lat);
    check("l1_rd_latency", lat, 2);
    check("l1_rd_data", r, 16'hC0DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
